// File: rtl/mux_n_pipe.sv
//==============================================================================
// Module   : mux_n_pipe
// Purpose  : Registered N-way datapath selector behind a 2-entry skid buffer
//            with a valid/ready handshake. Out-of-range selects return
//            DEFAULT_VAL, flag the beat, and bump a saturating error counter.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mux_n_pipe #(
    parameter int                WIDTH       = 32,
    parameter int                CHANNELS    = 3,
    parameter int                SEL_W       = 2,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEL_W-1:0]            sel,
    input  logic [CHANNELS*WIDTH-1:0]   data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            data_out,
    output logic [SEL_W-1:0]            sel_out,
    output logic                        sel_err,
    input  logic                        clr_err,
    output logic [15:0]                 err_count
);

    // Channel count widened by one bit so sel can be compared without truncation
    localparam logic [SEL_W:0] c_chanCount = (SEL_W+1)'(CHANNELS);
    localparam logic [15:0]    c_errMax    = 16'hFFFF;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } stateT;

    stateT              r_state;
    stateT              w_nextState;
    logic               r_inReady;

    // Main register drives the outputs; skid register holds the overflow beat
    logic [WIDTH-1:0]   r_mainData;
    logic [SEL_W-1:0]   r_mainSel;
    logic               r_mainErr;
    logic [WIDTH-1:0]   r_skidData;
    logic [SEL_W-1:0]   r_skidSel;
    logic               r_skidErr;
    logic [15:0]        r_errCount;

    logic [WIDTH-1:0]   w_chan [CHANNELS];
    logic [WIDTH-1:0]   w_beatData;
    logic               w_beatErr;
    logic               w_accept;
    logic               w_pop;
    logic               w_acceptErr;
    logic               w_loadMainIn;
    logic               w_loadMainSkid;
    logic               w_loadSkid;

    // Unflatten the channel bus
    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            assign w_chan[k] = data_in[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_accept    = in_valid & r_inReady;
    assign w_pop       = out_valid & out_ready;
    assign w_beatErr   = ({1'b0, sel} >= c_chanCount);
    assign w_acceptErr = w_accept & w_beatErr;

    // Beat formation: explicit compare loop keeps out-of-range selects off the array index
    always_comb begin
        w_beatData = DEFAULT_VAL;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                w_beatData = w_chan[k];
            end
        end
    end

    // Next-state and load-enable decode for the skid buffer
    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_nextState  = S_ONE;
                    w_loadMainIn = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_pop) begin
                    w_loadMainIn = 1'b1;
                end else if (w_accept) begin
                    w_nextState = S_TWO;
                    w_loadSkid  = 1'b1;
                end else if (w_pop) begin
                    w_nextState = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_nextState    = S_ONE;
                    w_loadMainSkid = 1'b1;
                end
            end
            default: begin
                w_nextState = S_EMPTY;
            end
        endcase
    end

    // State register; in_ready is registered from the next state so it has no input path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_inReady <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_inReady <= (w_nextState != S_TWO);
        end
    end

    // Main and skid payload registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mainData <= '0;
            r_mainSel  <= '0;
            r_mainErr  <= 1'b0;
            r_skidData <= '0;
            r_skidSel  <= '0;
            r_skidErr  <= 1'b0;
        end else begin
            if (w_loadMainIn) begin
                r_mainData <= w_beatData;
                r_mainSel  <= sel;
                r_mainErr  <= w_beatErr;
            end else if (w_loadMainSkid) begin
                r_mainData <= r_skidData;
                r_mainSel  <= r_skidSel;
                r_mainErr  <= r_skidErr;
            end
            if (w_loadSkid) begin
                r_skidData <= w_beatData;
                r_skidSel  <= sel;
                r_skidErr  <= w_beatErr;
            end
        end
    end

    // Saturating error counter; a clear coinciding with an erroring accept lands on 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_errCount <= '0;
        end else if (clr_err) begin
            r_errCount <= {15'd0, w_acceptErr};
        end else if (w_acceptErr && (r_errCount != c_errMax)) begin
            r_errCount <= r_errCount + 16'd1;
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = (r_state != S_EMPTY);
    assign data_out  = r_mainData;
    assign sel_out   = r_mainSel;
    assign sel_err   = r_mainErr;
    assign err_count = r_errCount;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
//==============================================================================
// Module   : tb_mux_n_pipe
// Purpose  : Scoreboard bench for mux_n_pipe. Instance A (3x32, directed
//            vectors) and instance B (5x8, randomised traffic) run side by side.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mux_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 3 channels, 32 bits
    logic         aRstN, aInValid, aInReady, aOutValid, aOutReady, aSelErr, aClrErr;
    logic [1:0]   aSel, aSelOut;
    logic [95:0]  aDataIn;
    logic [31:0]  aDataOut;
    logic [15:0]  aErrCount;
    logic [34:0]  qA [$];
    logic [34:0]  eA;

    // Instance B: 5 channels, 8 bits
    logic         bRstN, bInValid, bInReady, bOutValid, bOutReady, bSelErr, bClrErr;
    logic [2:0]   bSel, bSelOut;
    logic [39:0]  bDataIn;
    logic [7:0]   bDataOut;
    logic [15:0]  bErrCount;
    logic [11:0]  qB [$];
    logic [11:0]  eB;
    int           bExpErr = 0;

    mux_n_pipe #(.WIDTH(32), .CHANNELS(3), .SEL_W(2), .DEFAULT_VAL(32'hDEADBEEF)) dutA (
        .clk(clk), .rst_n(aRstN), .in_valid(aInValid), .in_ready(aInReady),
        .sel(aSel), .data_in(aDataIn), .out_valid(aOutValid), .out_ready(aOutReady),
        .data_out(aDataOut), .sel_out(aSelOut), .sel_err(aSelErr),
        .clr_err(aClrErr), .err_count(aErrCount)
    );

    mux_n_pipe #(.WIDTH(8), .CHANNELS(5), .SEL_W(3), .DEFAULT_VAL(8'hA5)) dutB (
        .clk(clk), .rst_n(bRstN), .in_valid(bInValid), .in_ready(bInReady),
        .sel(bSel), .data_in(bDataIn), .out_valid(bOutValid), .out_ready(bOutReady),
        .data_out(bDataOut), .sel_out(bSelOut), .sel_err(bSelErr),
        .clr_err(bClrErr), .err_count(bErrCount)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hand-computed beats for instance A: {sel_err, sel_out, data_out}
    function automatic logic [34:0] expA(input logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, 2'd0, 32'h11111111};
            2'd1:    return {1'b0, 2'd1, 32'h22222222};
            2'd2:    return {1'b0, 2'd2, 32'h33333333};
            default: return {1'b1, 2'd3, 32'hDEADBEEF};
        endcase
    endfunction

    // Reference beat for instance B
    function automatic logic [11:0] expB(input logic [2:0] s, input logic [39:0] d);
        logic [7:0] v;
        if (s < 3'd5) v = d[s*8 +: 8];
        else          v = 8'hA5;
        return {(s >= 3'd5), s, v};
    endfunction

    // One cycle on A: drive after the edge, record acceptance at the negedge
    task automatic cycA(input logic v, input logic [1:0] s, input logic ordy,
                        input logic clr, output logic acc);
        aInValid  = v;
        aSel      = s;
        aOutReady = ordy;
        aClrErr   = clr;
        @(negedge clk);
        acc = v && aInReady && aRstN;
        if (acc) qA.push_back(expA(s));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor A
    always @(negedge clk) begin
        if (aOutValid && aOutReady) begin
            if (qA.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monA_unexpected: got beat 0x%0h, expected none", {aSelErr, aSelOut, aDataOut});
            end else begin
                eA = qA.pop_front();
                check("monA_beat", {29'd0, aSelErr, aSelOut, aDataOut}, {29'd0, eA});
            end
        end
    end

    // Scoreboard monitor B
    always @(negedge clk) begin
        if (bOutValid && bOutReady) begin
            if (qB.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monB_unexpected: got beat 0x%0h, expected none", {bSelErr, bSelOut, bDataOut});
            end else begin
                eB = qB.pop_front();
                check("monB_beat", {52'd0, bSelErr, bSelOut, bDataOut}, {52'd0, eB});
            end
        end
    end

    // Global time limit
    initial begin
        #900000;
        $display("FAIL timeout: got no completion, expected finish before 900000ns");
        $fatal(1, "time limit");
    end

    task automatic runA();
        logic acc;
        aRstN = 1'b0; aInValid = 1'b1; aSel = 2'd1; aOutReady = 1'b0; aClrErr = 1'b0;
        aDataIn = {32'h33333333, 32'h22222222, 32'h11111111};
        repeat (2) @(posedge clk);
        #1;
        check("A_rst_out_valid", aOutValid, 0);
        check("A_rst_in_ready", aInReady, 1);
        check("A_rst_err_count", aErrCount, 0);
        check("A_rst_data_sel", {aDataOut, aSelOut, aSelErr}, 0);
        aInValid = 1'b0;
        aRstN = 1'b1;
        cycA(0, 0, 1, 0, acc);
        check("A_rst_beat_discarded", aOutValid, 0);

        // Streaming with out_ready high
        cycA(1, 0, 1, 0, acc);
        check("A_stream_lat1", {aOutValid, aDataOut}, {1'b1, 32'h11111111});
        check("A_stream_ready0", aInReady, 1);
        cycA(1, 1, 1, 0, acc);
        check("A_stream_d1", aDataOut, 32'h22222222);
        cycA(1, 2, 1, 0, acc);
        check("A_stream_d2", aDataOut, 32'h33333333);
        check("A_stream_ready2", aInReady, 1);
        cycA(0, 0, 1, 0, acc);
        check("A_stream_drained", aOutValid, 0);

        // Back-pressure: third beat must be refused
        cycA(1, 0, 0, 0, acc);
        check("A_bp_ready_after1", aInReady, 1);
        cycA(1, 1, 0, 0, acc);
        check("A_bp_ready_after2", aInReady, 0);
        check("A_bp_frozen", aDataOut, 32'h11111111);
        cycA(1, 2, 0, 0, acc);
        check("A_bp_third_refused", acc, 0);
        check("A_bp_still_frozen", {aOutValid, aDataOut, aSelOut}, {1'b1, 32'h11111111, 2'd0});
        cycA(1, 2, 1, 0, acc);
        check("A_bp_ready_back", aInReady, 1);
        cycA(1, 2, 1, 0, acc);
        check("A_bp_third_taken", acc, 1);
        cycA(0, 0, 1, 0, acc);
        cycA(0, 0, 1, 0, acc);
        check("A_bp_drained", {aOutValid, 1'b0}, 0);

        // Out-of-range select
        cycA(1, 3, 0, 0, acc);
        check("A_oor_beat", {aSelErr, aSelOut, aDataOut}, {1'b1, 2'd3, 32'hDEADBEEF});
        check("A_oor_err_count", aErrCount, 1);
        cycA(0, 0, 1, 0, acc);

        // Saturation: 0xFFFE more erroring beats reach 0xFFFF, one more holds there
        for (int i = 0; i < 16'hFFFE; i++) cycA(1, 3, 1, 0, acc);
        check("A_cnt_at_max", aErrCount, 16'hFFFF);
        cycA(1, 3, 1, 0, acc);
        check("A_cnt_saturated", aErrCount, 16'hFFFF);
        cycA(0, 0, 1, 0, acc);
        cycA(0, 0, 1, 1, acc);
        check("A_cnt_clear", aErrCount, 0);
        cycA(1, 3, 1, 1, acc);
        check("A_cnt_clear_with_err", aErrCount, 1);
        cycA(1, 3, 1, 0, acc);
        check("A_cnt_inc_again", aErrCount, 2);
        cycA(0, 0, 1, 0, acc);

        // Reset while holding two beats
        cycA(1, 0, 0, 0, acc);
        cycA(1, 1, 0, 0, acc);
        check("A_two_ready_low", aInReady, 0);
        aRstN = 1'b0;
        cycA(0, 0, 0, 0, acc);
        qA.delete();
        check("A_midrst_out_valid", aOutValid, 0);
        check("A_midrst_in_ready", aInReady, 1);
        check("A_midrst_err_count", aErrCount, 0);
        aRstN = 1'b1;
        cycA(1, 1, 1, 0, acc);
        check("A_postrst_accept", acc, 1);
        check("A_postrst_beat", {aOutValid, aDataOut}, {1'b1, 32'h22222222});
        cycA(0, 0, 1, 0, acc);
        check("A_final_empty", aOutValid, 0);
    endtask

    task automatic runB();
        logic [63:0] rnd;
        bRstN = 1'b0; bInValid = 1'b0; bSel = '0; bDataIn = '0; bOutReady = 1'b0; bClrErr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("B_rst_state", {bOutValid, bInReady, bErrCount}, {1'b0, 1'b1, 16'd0});
        bRstN = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            rnd       = {$urandom, $urandom};
            bInValid  = rnd[40];
            bOutReady = (rnd[42:41] != 2'b00);
            bSel      = rnd[45:43];
            bDataIn   = rnd[39:0];
            @(negedge clk);
            if (bInValid && bInReady) begin
                qB.push_back(expB(bSel, bDataIn));
                if (bSel >= 3'd5) bExpErr++;
            end
            @(posedge clk);
            #1;
        end
        bInValid  = 1'b0;
        bOutReady = 1'b1;
        for (int i = 0; i < 8 && qB.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("B_drain_queue", qB.size(), 0);
        check("B_drain_valid", bOutValid, 0);
        check("B_err_count", bErrCount, bExpErr);
    endtask

    initial begin
        fork
            runA();
            runB();
        join
        check("A_queue_empty", qA.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised, registered N-way datapath selector with a valid/ready handshake, replacing the fixed 3-input combinational 32-bit selector in the CPU datapath. Where a selector sits on a timing-critical path, it adds one pipeline stage and stalls cleanly under back-pressure; typical uses are the writeback-source select and the ALU-operand forward select. Out-of-range selects no longer drive high-impedance. They return a defined value, flag the beat, and increment a saturating error counter.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- CHANNELS, 3, number of input channels (2..16)
- SEL_W, 2, select width; SEL_W >= clog2(CHANNELS)
- DEFAULT_VAL, 0, value driven for an out-of-range select (WIDTH bits)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat (registered)
- sel  in  SEL_W  channel select for the beat
- data_in  in  CHANNELS*WIDTH  flattened channels; channel k = bits [k*WIDTH +: WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- data_out  out  WIDTH  selected data
- sel_out  out  SEL_W  select value that produced data_out
- sel_err  out  1  beat had sel >= CHANNELS
- clr_err  in  1  synchronous clear of err_count
- err_count  out  16  saturating count of accepted out-of-range beats

## Operation
- Accept: in_valid & in_ready at a rising edge. Pop: out_valid & out_ready at a rising edge.
- Beat formed at accept:
  - data = channel[sel] if sel < CHANNELS, else DEFAULT_VAL.
  - sel_err = (sel >= CHANNELS).
  - sel_out = sel.
- Storage is a 2-entry skid buffer (main register drives the outputs, plus one skid register). State machine:
  - EMPTY: accept -> ONE (load main).
  - ONE:
    - accept & pop -> ONE (main <- new beat).
    - accept & !pop -> TWO (skid <- new beat).
    - !accept & pop -> EMPTY.
    - otherwise hold.
  - TWO: pop -> ONE (main <- skid). Accept is impossible in this state.
- Output and handshake signals:
  - out_valid = state != EMPTY.
  - in_ready = next state != TWO; it is registered.
  - data_out, sel_out and sel_err are stable while out_valid & !out_ready.
- Beats leave in acceptance order. None is dropped or duplicated.
- err_count:
  - Increments by 1 on each accepted beat with sel_err.
  - Saturates at 0xFFFF.
  - clr_err in the same cycle as an erroring accept gives a result of 1. clr_err alone gives 0.
- Non-power-of-two CHANNELS must work, e.g. CHANNELS=3 with SEL_W=2, where sel=3 is out of range.

## Timing
- Latency: accept at edge n gives out_valid at edge n (visible in cycle n+1) when EMPTY, i.e. one cycle.
- Throughput: 1 beat/cycle when out_ready is held high.
- in_ready goes low no earlier than the cycle after the second un-popped beat is accepted, and returns high the cycle after a pop from TWO.
- Reset values while rst_n is low, and after the first edge with rst_n low:
  - state EMPTY, out_valid 0, data_out 0, sel_out 0, sel_err 0, err_count 0, in_ready 1.
  - Beats presented while rst_n is low are discarded.
- Reset mid-operation: all buffered beats are lost, with no output pulse. The edge after rst_n rises can accept.
- No combinational path from in_valid or out_ready to in_ready. data_in and sel are sampled only at accept.

## Test plan
- Streaming, CHANNELS=3, WIDTH=32, out_ready=1: beats sel=0,1,2 with channels {0x11111111, 0x22222222, 0x33333333} -> data_out 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Back-pressure: out_ready=0, three beats offered -> 2 accepted, in_ready=0 after the second, data_out frozen at beat 1. Release out_ready -> beats 1, 2, then 3 in order, with no loss.
- Out-of-range: sel=3 with CHANNELS=3 and DEFAULT_VAL=0xDEADBEEF -> data_out 0xDEADBEEF, sel_err=1, sel_out=3, err_count=1.
- Counter: 0xFFFF erroring beats plus one more -> err_count holds at 0xFFFF. clr_err alone -> 0. clr_err together with an erroring accept -> 1.
- Reset in state TWO: rst_n low for one cycle -> out_valid 0, in_ready 1, err_count 0. The next beat sel=1 appears after 1 cycle with the correct data.
- Random: CHANNELS=5, WIDTH=8, random in_valid, out_ready and sel in 0..7 over 10k cycles -> output stream matches a reference queue model. err_count equals the number of accepted sel>=5 beats.
